nios2_system_v0_sys_clk_tick_engine: RTL and testbench

Hardware service engine for the system clock timer: drives the timer's 16-bit Avalon-MM slave port and consumes its `irq`. After enable it programs the period, starts the timer in continuous mode with interrupts enabled, acknowledges every timeout without CPU involvement, and exports a one-cycle tick pulse, a free-running 32-bit tick count and on-demand snapshots of the timer's current count.

---
 rtl/nios2_system_v0_sys_clk_tick_engine.sv | 164 ++++++++++++++++
 tb/tb_nios2_system_v0_sys_clk_tick_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_system_v0_sys_clk_tick_engine.sv
// System clock tick engine.
// Owns the interval timer's 16-bit slave port: programs the period, starts the
// timer in continuous mode with interrupts, acknowledges each timeout in
// hardware, counts ticks and takes on-demand snapshots of the live count.
module nios2_system_v0_sys_clk_tick_engine #(
    parameter logic [31:0] PERIOD = 32'd49999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        snap_req,
    input  logic        timer_irq,
    input  logic [15:0] avm_readdata,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid,
    output logic        running
);
    // Timer register map and control words
    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  ADDR_PERIODH = 3'd3;
    localparam logic [2:0]  ADDR_SNAPL   = 3'd4;
    localparam logic [2:0]  ADDR_SNAPH   = 3'd5;
    localparam logic [15:0] CTRL_START   = 16'h0007;  // ITO | CONT | START
    localparam logic [15:0] CTRL_STOP    = 16'h0008;  // STOP

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_CLR,
        S_SNAP_WR,
        S_SNAP_RDL,
        S_SNAP_RDH,
        S_SNAP_CAP,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [2:0]  addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        write_n_q, write_n_d;
    logic [15:0] wdata_q, wdata_d;
    logic        tick_q, tick_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic        snap_valid_q, snap_valid_d;
    logic        running_q, running_d;

    // Next state: RUN arbitrates stop > timeout acknowledge > snapshot
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (enable) state_d = S_WR_PL;
            S_WR_PL:    state_d = S_WR_PH;
            S_WR_PH:    state_d = S_WR_CTRL;
            S_WR_CTRL:  state_d = S_RUN;
            S_RUN: begin
                if (!enable)        state_d = S_STOP;
                else if (timer_irq) state_d = S_CLR;
                else if (pend_q)    state_d = S_SNAP_WR;
            end
            S_CLR:      state_d = S_RUN;
            S_SNAP_WR:  state_d = S_SNAP_RDL;
            S_SNAP_RDL: state_d = S_SNAP_RDH;
            S_SNAP_RDH: state_d = S_SNAP_CAP;
            S_SNAP_CAP: state_d = S_RUN;
            S_STOP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus cycle for the state being entered, so the registered bus lines up with the state
    always_comb begin
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = 3'd0;
        wdata_d   = 16'h0000;
        case (state_d)
            S_WR_PL:    begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_PERIODL; wdata_d = PERIOD[15:0];  end
            S_WR_PH:    begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_PERIODH; wdata_d = PERIOD[31:16]; end
            S_WR_CTRL:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_START;    end
            S_CLR:      begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_STATUS;                          end
            S_SNAP_WR:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_SNAPL;                           end
            S_SNAP_RDL: begin cs_d = 1'b1; addr_d = ADDR_SNAPL;                                             end
            S_SNAP_RDH: begin cs_d = 1'b1; addr_d = ADDR_SNAPH;                                             end
            S_STOP:     begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_STOP;     end
            default:    ;
        endcase
    end

    // Tick, snapshot and pending-request bookkeeping
    always_comb begin
        tick_d       = (state_d == S_CLR);
        running_d    = state_d inside {S_RUN, S_CLR, S_SNAP_WR, S_SNAP_RDL, S_SNAP_RDH, S_SNAP_CAP};
        tick_count_d = tick_count_q;
        if (state_q == S_CLR) tick_count_d = tick_count_q + 32'd1;

        // Read data arrives one cycle after its address, so the low half is
        // on the bus during RDH and the high half during CAP. snap_valid rises
        // the cycle both halves are present in snap_value.
        snap_value_d = snap_value_q;
        if (state_q == S_SNAP_RDH) snap_value_d[15:0]  = avm_readdata;
        if (state_q == S_SNAP_CAP) snap_value_d[31:16] = avm_readdata;
        snap_valid_d = (state_q == S_SNAP_CAP);

        // Pending is consumed when a snapshot starts; a request in that same
        // RUN cycle is covered by the latch about to happen, while requests
        // arriving anywhere in the sequence (CAP included) stay pending.
        pend_d = pend_q | snap_req;
        if (state_q == S_RUN && state_d == S_SNAP_WR) pend_d = 1'b0;
        if (state_d == S_IDLE) pend_d = 1'b0;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            wdata_q      <= 16'h0000;
            tick_q       <= 1'b0;
            tick_count_q <= 32'd0;
            snap_value_q <= 32'd0;
            snap_valid_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            wdata_q      <= wdata_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            running_q    <= running_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = wdata_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign snap_value     = snap_value_q;
    assign snap_valid     = snap_valid_q;
    assign running        = running_q;

endmodule

// File: tb/tb_nios2_system_v0_sys_clk_tick_engine.sv
// Bench for the tick engine: a behavioural interval-timer model answers the
// bus; stimulus pushes expectations into queues and a monitor on the falling
// edge pops and compares them against what the engine presents.
module tb_nios2_system_v0_sys_clk_tick_engine;
    localparam logic [31:0] TB_PERIOD = 32'd199;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        snap_req = 1'b0;
    logic        timer_irq;
    logic [15:0] avm_readdata;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic        tick;
    logic [31:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic        running;

    always #5 clk = ~clk;

    nios2_system_v0_sys_clk_tick_engine #(.PERIOD(TB_PERIOD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .snap_req(snap_req),
        .timer_irq(timer_irq), .avm_readdata(avm_readdata),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .tick(tick), .tick_count(tick_count), .snap_value(snap_value),
        .snap_valid(snap_valid), .running(running)
    );

    typedef struct { logic [2:0] addr; logic [15:0] data; bit seq; } wr_t;
    typedef struct { int cyc; logic [2:0] addr; } rd_t;
    typedef struct { int cyc; logic [31:0] val; } sv_t;

    wr_t ctrl_q[$];
    rd_t rd_q[$];
    sv_t snap_q[$];
    int  req_q[$];
    int  clr_q[$];
    int  clr_cycles[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] exp_ticks = 32'd0;
    int          snap_count = 0;
    int          last_snapwr = -1;
    int          last_stop_cyc = -1;
    int          last_ctrl_cyc = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- interval timer model ----------------
    logic [31:0] tm_period = 32'd0;
    logic [31:0] tm_count = 32'd0;
    logic [31:0] tm_snap = 32'd0;
    logic        tm_run = 1'b0;
    logic        tm_ito = 1'b0;
    logic        tm_to = 1'b0;
    logic [15:0] tm_rdata = 16'h0000;
    wire         tm_wr = avm_chipselect & ~avm_write_n;

    assign timer_irq    = tm_to & tm_ito;
    assign avm_readdata = tm_rdata;

    always @(posedge clk) begin
        if (tm_run) begin
            if (tm_count == 32'd0) begin
                tm_count <= tm_period;
                if (!(tm_wr && avm_address == 3'd0) && !tm_to) begin
                    tm_to <= 1'b1;
                    clr_q.push_back(1);
                end
            end else begin
                tm_count <= tm_count - 32'd1;
            end
        end
        if (tm_wr) begin
            case (avm_address)
                3'd0: tm_to <= 1'b0;
                3'd1: begin
                    tm_ito <= avm_writedata[0];
                    if (avm_writedata[2]) tm_run <= 1'b1;
                    if (avm_writedata[3]) tm_run <= 1'b0;
                end
                3'd2: begin
                    tm_period[15:0] <= avm_writedata;
                    tm_count <= {tm_period[31:16], avm_writedata};
                end
                3'd3: begin
                    tm_period[31:16] <= avm_writedata;
                    tm_count <= {avm_writedata, tm_period[15:0]};
                end
                3'd4, 3'd5: tm_snap <= tm_count;
                default: ;
            endcase
        end
        if (avm_chipselect && avm_write_n)
            tm_rdata <= (avm_address == 3'd4) ? tm_snap[15:0] :
                        (avm_address == 3'd5) ? tm_snap[31:16] : 16'h0000;
        else
            tm_rdata <= 16'h0000;
    end

    // ---------------- monitor / scoreboard ----------------
    bit   chk_cnt = 0;
    bit   chk_run = 0;
    logic run_exp = 1'b0;
    wr_t  mon_w;
    bit   mon_sv;
    bit   mon_rd_exp;
    bit   mon_rd;
    int   mon_n;

    always @(negedge clk) begin
        if (reset) begin
            chk_cnt = 0;
            chk_run = 0;
        end else begin
            if (chk_cnt) begin
                check("tick_count", tick_count, exp_ticks);
                chk_cnt = 0;
            end
            if (chk_run) begin
                check("running", running, run_exp);
                chk_run = 0;
            end
            if (!avm_chipselect)
                check("idle_bus", {avm_write_n, avm_address, avm_writedata}, {1'b1, 3'd0, 16'h0000});
            check("tick_with_clr", tick, tm_wr && avm_address == 3'd0);

            mon_sv = (snap_q.size() > 0) && (snap_q[0].cyc == cyc);
            check("snap_valid", snap_valid, mon_sv);
            if (mon_sv) begin
                check("snap_value", snap_value, snap_q[0].val);
                $display("[%0d] SNAP value=%08h", cyc, snap_value);
                void'(snap_q.pop_front());
            end

            mon_rd     = avm_chipselect && avm_write_n;
            mon_rd_exp = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            check("read_slot", mon_rd, mon_rd_exp);
            if (mon_rd && mon_rd_exp) check("read_addr", avm_address, rd_q[0].addr);
            if (mon_rd_exp) void'(rd_q.pop_front());
            if (mon_rd) $display("[%0d] RD addr=%0d", cyc, avm_address);

            if (tm_wr) begin
                $display("[%0d] WR addr=%0d data=%04h tick=%0b", cyc, avm_address, avm_writedata, tick);
                case (avm_address)
                    3'd0: begin
                        check("clr_data", avm_writedata, 16'h0000);
                        check("clr_expected", clr_q.size() > 0, 1);
                        if (clr_q.size() > 0) void'(clr_q.pop_front());
                        exp_ticks = exp_ticks + 32'd1;
                        chk_cnt = 1;
                        clr_cycles.push_back(cyc);
                    end
                    3'd1, 3'd2, 3'd3: begin
                        check("ctrl_expected", ctrl_q.size() > 0, 1);
                        if (ctrl_q.size() > 0) begin
                            mon_w = ctrl_q.pop_front();
                            check("ctrl_write", {avm_address, avm_writedata}, {mon_w.addr, mon_w.data});
                            if (mon_w.seq) check("ctrl_back_to_back", cyc, last_ctrl_cyc + 1);
                        end
                        if (avm_address == 3'd1 && avm_writedata == 16'h0007) begin
                            run_exp = 1'b1; chk_run = 1;
                        end
                        if (avm_address == 3'd1 && avm_writedata == 16'h0008) begin
                            run_exp = 1'b0; chk_run = 1; last_stop_cyc = cyc;
                        end
                        last_ctrl_cyc = cyc;
                    end
                    3'd4: begin
                        check("snap_wr_data", avm_writedata, 16'h0000);
                        mon_n = 0;
                        while (req_q.size() > 0 && req_q[0] < cyc) begin
                            void'(req_q.pop_front());
                            mon_n++;
                        end
                        check("snap_requested", mon_n > 0, 1);
                        rd_q.push_back('{cyc + 1, 3'd4});
                        rd_q.push_back('{cyc + 2, 3'd5});
                        snap_q.push_back('{cyc + 4, tm_count});
                        snap_count++;
                        last_snapwr = cyc;
                    end
                    default: check("write_addr_legal", avm_address, 3'd0);
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic enable_on();
        enable = 1'b1;
        ctrl_q.push_back('{3'd2, TB_PERIOD[15:0], 1'b0});
        ctrl_q.push_back('{3'd3, TB_PERIOD[31:16], 1'b1});
        ctrl_q.push_back('{3'd1, 16'h0007, 1'b1});
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        req_q.push_back(cyc);
        step();
        snap_req = 1'b0;
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_bus_flags"},
              {avm_chipselect, avm_write_n, avm_address, avm_writedata, tick, snap_valid, running},
              {1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0});
        check({nm, "_tick_count"}, tick_count, 32'd0);
        check({nm, "_snap_value"}, snap_value, 32'd0);
    endtask

    task automatic random_snaps(input int iters);
        for (int i = 0; i < iters; i++) begin
            repeat ($urandom_range(1, 30)) step();
            pulse_snap();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 3)) step();
                pulse_snap();
            end
        end
        repeat (40) step();
    endtask

    initial begin
        int t_irq;
        int base;
        int ncl;

        // reset state
        repeat (3) step();
        check_reset_state("reset");
        reset = 1'b0;
        step();

        // init sequence and three periods
        enable_on();
        for (int i = 0; i < 4 * 200 + 50 && clr_cycles.size() < 3; i++) step();
        check("three_ticks_seen", clr_cycles.size() >= 3, 1);
        if (clr_cycles.size() >= 3) begin
            check("tick_spacing_1", clr_cycles[1] - clr_cycles[0], TB_PERIOD + 1);
            check("tick_spacing_2", clr_cycles[2] - clr_cycles[1], TB_PERIOD + 1);
        end
        step();
        check("tick_count_3", tick_count, 32'd3);

        // irq and snap_req in the same cycle, then a second request mid-sequence
        for (int i = 0; i < 300 && timer_irq !== 1'b1; i++) step();
        t_irq = cyc;
        base = snap_count;
        ncl = clr_cycles.size();
        pulse_snap();
        for (int i = 0; i < 20 && snap_count == base; i++) step();
        check("irq_to_clr", (clr_cycles.size() > ncl) ? clr_cycles[ncl] : -1, t_irq + 1);
        check("snap_after_clr", last_snapwr, t_irq + 3);
        pulse_snap();
        repeat (20) step();
        check("second_snap_count", snap_count, base + 2);

        // randomized snapshot traffic with timeouts running underneath
        random_snaps(60);

        // tick_count wrap
        ncl = clr_cycles.size();
        for (int i = 0; i < 250 && clr_cycles.size() == ncl; i++) step();
        step();
        force dut.tick_count_q = 32'hFFFF_FFFF;
        exp_ticks = 32'hFFFF_FFFF;
        step();
        release dut.tick_count_q;
        ncl = clr_cycles.size();
        for (int i = 0; i < 250 && clr_cycles.size() == ncl; i++) step();
        step();
        check("tick_count_wrap", tick_count, 32'd0);

        // disable while a snapshot is in flight
        base = snap_count;
        pulse_snap();
        for (int i = 0; i < 20 && snap_count == base; i++) step();
        enable = 1'b0;
        ctrl_q.push_back('{3'd1, 16'h0008, 1'b0});
        repeat (15) step();
        check("stop_after_snapshot", last_stop_cyc > last_snapwr + 3, 1);
        check("snap_done_before_stop", snap_q.size(), 0);
        check("running_after_stop", running, 1'b0);

        // re-enable: full init again
        enable_on();
        repeat (10) step();
        check("reinit_done", ctrl_q.size(), 0);
        check("running_after_reinit", running, 1'b1);
        random_snaps(20);
        enable = 1'b0;
        ctrl_q.push_back('{3'd1, 16'h0008, 1'b0});
        repeat (20) step();

        check("ctrl_drained", ctrl_q.size(), 0);
        check("req_drained", req_q.size(), 0);
        check("rd_drained", rd_q.size(), 0);
        check("snap_drained", snap_q.size(), 0);
        check("clr_drained", clr_q.size(), tm_to ? 1 : 0);

        // reset during WR_PH
        enable_on();
        for (int i = 0; i < 10 && !(tm_wr && avm_address == 3'd3); i++) step();
        check("reached_wr_ph", {tm_wr, avm_address}, {1'b1, 3'd3});
        reset = 1'b1;
        ctrl_q.delete();
        exp_ticks = 32'd0;
        enable = 1'b0;
        step();
        check_reset_state("mid_init_reset");
        step();
        reset = 1'b0;
        repeat (5) step();
        check("idle_after_reset", {avm_chipselect, running}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
